// File: rtl/instr_fetch_unit.sv
// Fetch stage: takes fetch addresses from PC_adder, issues one instruction-memory
// read at a time and returns {pc, instruction} pairs to decode through a small FIFO.
module instr_fetch_unit #(
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misaligned
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic        latch_pc;

  logic [31:0] q_pc    [QUEUE_DEPTH];
  logic [31:0] q_instr [QUEUE_DEPTH];
  logic        q_mis   [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        push, pop, handshake, misaligned;
  logic [31:0] push_pc, push_instr;
  logic        push_mis;

  assign pc_ready       = !reset && (state == IDLE) && (count < DEPTH_C) && !flush;
  assign handshake      = pc_valid && pc_ready;
  assign misaligned     = (pc_in[1:0] != 2'b00);
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = {pc_q[31:2], 2'b00};

  assign out_valid      = (count != '0) && !flush;
  assign pop            = out_valid && out_ready;
  assign out_pc         = q_pc[rd_ptr];
  assign out_instr      = q_instr[rd_ptr];
  assign out_misaligned = q_mis[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      if (latch_pc) pc_q <= pc_in;
    end
  end

  always_comb begin
    state_nxt  = state;
    latch_pc   = 1'b0;
    push       = 1'b0;
    push_pc    = pc_q;
    push_instr = imem_resp_data;
    push_mis   = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (misaligned) begin
            // Misaligned fetches never reach memory; decode sees a NOP tagged misaligned.
            push       = 1'b1;
            push_pc    = pc_in;
            push_instr = NOP_INSTR;
            push_mis   = 1'b1;
          end else begin
            latch_pc  = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (flush)               state_nxt = imem_req_ready ? DRAIN : IDLE;
        else if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          push      = !flush;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_resp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        q_mis[i]   <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= push_pc;
        q_instr[wr_ptr] <= push_instr;
        q_mis[wr_ptr]   <= push_mis;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
